// File: rtl/bcd_scan_counter_if.sv
// Control and display bus of the four-digit BCD counter / display scanner.
// The counter is the slave; the surrounding control logic and display path form the master.
interface bcd_scan_counter_if;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic        cnt_en;
  logic        up;
  logic        blank_en;
  logic [15:0] value;
  logic        carry;
  logic [3:0]  dig_bcd;
  logic        dig_en;
  logic [3:0]  dig_sel;

  modport master (
    output clr, load, load_val, cnt_en, up, blank_en,
    input  value, carry, dig_bcd, dig_en, dig_sel
  );

  modport slave (
    input  clr, load, load_val, cnt_en, up, blank_en,
    output value, carry, dig_bcd, dig_en, dig_sel
  );
endinterface

// File: rtl/bcd_scan_counter.sv
// Four-digit BCD up/down counter with wrap pulse, plus a free-running digit scanner
// that feeds one digit per slot (with leading-zero blanking) to a 7-segment decoder.
module bcd_scan_counter #(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  bcd_scan_counter_if.slave  bus
);

  localparam int DIV_W = 16;

  logic [15:0]      r_value;
  logic             r_carry;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_scan_idx;
  logic [3:0]       r_dig_sel;
  logic [3:0]       r_dig_bcd;
  logic             r_dig_en;

  logic [15:0] w_load_bcd;
  logic [15:0] w_inc;
  logic [15:0] w_dec;
  logic        w_inc_wrap;
  logic        w_dec_wrap;
  logic [15:0] w_next;
  logic        w_next_carry;
  logic        w_div_tc;
  logic [3:0]  w_sel_digit;
  logic        w_sel_nonzero;

  // Out-of-range nibbles load as 0 so every digit stays within 0..9.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    w_load_bcd = '0;
    for (int i = 0; i < 4; i++) begin
      w_load_bcd[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd0 : bus.load_val[4*i +: 4];
    end
  end

  // Decimal ripple: the carry/borrow survives only while digits sit at 9 (up) or 0 (down).
  always_comb begin
    w_inc      = r_value;
    w_dec      = r_value;
    w_inc_wrap = 1'b1;
    w_dec_wrap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (w_inc_wrap) begin
        if (r_value[4*i +: 4] == 4'd9) begin
          w_inc[4*i +: 4] = 4'd0;
        end else begin
          w_inc[4*i +: 4] = r_value[4*i +: 4] + 4'd1;
          w_inc_wrap      = 1'b0;
        end
      end
      if (w_dec_wrap) begin
        if (r_value[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_value[4*i +: 4] - 4'd1;
          w_dec_wrap      = 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_next       = r_value;
    w_next_carry = 1'b0;
    if (bus.clr) begin
      w_next = '0;
    end else if (bus.load) begin
      w_next = w_load_bcd;
    end else if (bus.cnt_en) begin
      w_next       = bus.up ? w_inc      : w_dec;
      w_next_carry = bus.up ? w_inc_wrap : w_dec_wrap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_carry <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_value <= w_next;
      r_carry <= w_next_carry;
    end
  end

  assign w_div_tc = (r_div == DIV_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div      <= '0;
      r_scan_idx <= 2'd0;
    end else if (w_div_tc) begin
      r_div      <= '0;
      r_scan_idx <= r_scan_idx + 2'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Digit i is shown if it or any higher digit is non-zero; digit 0 always shows.
  always_comb begin
    w_sel_digit   = r_value[4*r_scan_idx +: 4];
    w_sel_nonzero = 1'b1;
    case (r_scan_idx)
      2'd1:    w_sel_nonzero = |r_value[15:4];
      2'd2:    w_sel_nonzero = |r_value[15:8];
      2'd3:    w_sel_nonzero = |r_value[15:12];
      default: w_sel_nonzero = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig_sel <= 4'b0001;
      r_dig_bcd <= 4'd0;
      r_dig_en  <= 1'b1;
    end else begin
      r_dig_sel <= 4'b0001 << r_scan_idx;
      r_dig_bcd <= w_sel_digit;
      r_dig_en  <= !bus.blank_en || w_sel_nonzero;
    end
  end

  assign bus.value   = r_value;
  assign bus.carry   = r_carry;
  assign bus.dig_sel = r_dig_sel;
  assign bus.dig_bcd = r_dig_bcd;
  assign bus.dig_en  = r_dig_en;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: directed scenarios plus random traffic, checked every
// clock against an integer-arithmetic model of the counter and scan schedule.
module tb_bcd_scan_counter;

  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bcd_scan_counter_if bus ();

  bcd_scan_counter #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int m_cnt;      // model count as a plain integer 0..9999
  int m_k;        // clock edges since reset release
  int p10 [4] = '{1, 10, 100, 1000};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'((n / p10[i]) % 10);
    return r;
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int n;
    n = 0;
    for (int i = 0; i < 4; i++) n += (lv[4*i +: 4] > 9) ? 0 : int'(lv[4*i +: 4]) * p10[i];
    return n;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_value"},   bus.value,             16'h0000);
    check({tag, "_carry"},   {15'd0, bus.carry},    16'd0);
    check({tag, "_dig_sel"}, {12'd0, bus.dig_sel},  16'h0001);
    check({tag, "_dig_bcd"}, {12'd0, bus.dig_bcd},  16'd0);
    check({tag, "_dig_en"},  {15'd0, bus.dig_en},   16'd1);
  endtask

  // One clock: drive inputs, advance the model, check every output 1 time unit after the edge.
  task automatic step(input bit c, input bit l, input bit e, input bit u, input bit b,
                      input logic [15:0] lv);
    int  prev;
    bit  exp_carry;
    int  slot;
    bit  exp_en;
    bus.clr = c; bus.load = l; bus.cnt_en = e; bus.up = u; bus.blank_en = b; bus.load_val = lv;
    @(posedge clk);
    prev      = m_cnt;
    exp_carry = 1'b0;
    if (c)      m_cnt = 0;
    else if (l) m_cnt = from_load(lv);
    else if (e) begin
      if (u) begin exp_carry = (m_cnt == 9999); m_cnt = (m_cnt + 1) % 10000;    end
      else   begin exp_carry = (m_cnt == 0);    m_cnt = (m_cnt + 9999) % 10000; end
    end
    m_k++;
    slot   = ((m_k - 1) / SCAN_DIV) % 4;
    exp_en = !b || slot == 0 || (prev / p10[slot]) != 0;
    #1;
    check("value",   bus.value,            to_bcd(m_cnt));
    check("carry",   {15'd0, bus.carry},   {15'd0, exp_carry});
    check("dig_sel", {12'd0, bus.dig_sel}, 16'(1 << slot));
    check("dig_bcd", {12'd0, bus.dig_bcd}, 16'((prev / p10[slot]) % 10));
    check("dig_en",  {15'd0, bus.dig_en},  {15'd0, exp_en});
  endtask

  task automatic idle(input int n, input bit b);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, b, 16'h0000);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.clr = 0; bus.load = 0; bus.cnt_en = 0; bus.up = 0; bus.blank_en = 0; bus.load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0;
    m_k   = 0;

    // Scan rotation from reset with blanking on: only digit 0 shows.
    idle(4 * SCAN_DIV + 1, 1'b1);

    // Carry ripple through two digits, no wrap.
    step(0, 1, 0, 0, 0, 16'h0998);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 0, 16'h0000);
    check("tp_1001", bus.value, 16'h1001);

    // Wrap in both directions, back to back.
    step(0, 1, 0, 0, 0, 16'h9999);
    step(0, 0, 1, 1, 0, 16'h0000);
    step(0, 0, 1, 0, 0, 16'h0000);
    check("tp_down_wrap", bus.value, 16'h9999);
    step(0, 0, 1, 1, 0, 16'h0000);
    step(0, 0, 1, 0, 0, 16'h0000);

    // Priority and load sanitising.
    step(1, 1, 1, 1, 0, 16'h1234);
    check("tp_clr_wins", bus.value, 16'h0000);
    step(0, 1, 0, 0, 0, 16'h1234);
    step(0, 1, 1, 1, 0, 16'hA5F3);
    check("tp_sanitize", bus.value, 16'h0503);

    // Blanking of 0040 over a full frame, then with blanking off.
    step(0, 1, 0, 0, 1, 16'h0040);
    idle(4 * SCAN_DIV, 1'b1);
    idle(4 * SCAN_DIV, 1'b0);

    // Random traffic, with boundary values favoured for loads.
    for (int i = 0; i < 600; i++) begin
      int          r;
      logic [15:0] lv;
      r = $urandom_range(0, 99);
      case ($urandom_range(0, 3))
        0:       lv = 16'h9999;
        1:       lv = 16'h0000;
        2:       lv = 16'h0001;
        default: lv = 16'($urandom);
      endcase
      step(r < 3, r < 12, $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), lv);
    end

    // Asynchronous reset mid-slot, then a full first slot after release.
    step(0, 1, 0, 0, 1, 16'h0057);
    idle(2, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    m_cnt = 0;
    m_k   = 0;
    idle(2 * SCAN_DIV + 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
